// File: rtl/control_path.sv
// control_path: main instruction decoder plus NZCV flag register and
// conditional-branch resolution (B.LT, CBZ) for the ARMv8-subset core.
// Optional macro FLAG_BYPASS_EN: lets a B.LT that directly follows a
// flag-setting instruction use the live ALU flags.
module control_path (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruct_bits,
  input  logic        negativef,
  input  logic        overflowf,
  input  logic        carryf,
  input  logic        zerof,
  input  logic        zero_comparator,
  output logic        flag_enable,
  output logic        BrTaken,
  output logic        Reg2Loc,
  output logic        RdLoc,
  output logic        RegWrite,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        UnCondBr,
  output logic        xsize_loc,
  output logic [2:0]  ALUSrc,
  output logic [2:0]  ALUOp,
  output logic [2:0]  MemtoReg,
  output logic [1:0]  ALU_first_i_sel
);

  // Field order matches the control-vector tables below
  typedef struct packed {
    logic       br;
    logic       reg2loc;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       uncondbr;
    logic       xsize;
    logic [2:0] alusrc;
    logic [2:0] aluop;
    logic [2:0] memtoreg;
    logic [1:0] first_sel;
    logic       flag_en;
    logic       rdloc;
  } ctrl_t;

  localparam ctrl_t C_NOP = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                              3'd0, 3'd0, 3'd0, 2'd0, 1'b0, 1'b0};

  logic [3:0]  r_flags;        // {N, Z, C, V}
  logic [10:0] w_op;
  logic        w_lt;
  ctrl_t       w_ctrl;
  logic        w_unused_bits;

  assign w_op = instruct_bits[31:21];

  // Z and C are kept for future condition codes; low instruction bits are
  // datapath fields this block does not decode.
  assign w_unused_bits = ^{r_flags[2:1], carryf, instruct_bits[20:0]};

`ifdef FLAG_BYPASS_EN
  logic r_flag_pending;

  // Remembers that the previous cycle wrote flags, so live flags are current
  always_ff @(posedge clk) begin
    if (reset) r_flag_pending <= 1'b0;
    else       r_flag_pending <= w_ctrl.flag_en;
  end

  assign w_lt = r_flag_pending ? (negativef ^ overflowf) : (r_flags[3] ^ r_flags[0]);
`else
  assign w_lt = r_flags[3] ^ r_flags[0];
`endif

  // Priority opcode decode; reset forces the NOP vector
  always_comb begin
    w_ctrl = C_NOP;
    if (reset)
      w_ctrl = C_NOP;
    else if (w_op[10:1] == 10'b1001000100)   // ADDI
      w_ctrl = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 3'd2, 3'd0, 2'd0, 1'b0, 1'b0};
    else if (w_op == 11'b10101011000)        // ADDS
      w_ctrl = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 3'd2, 3'd0, 2'd0, 1'b1, 1'b0};
    else if (w_op[10:5] == 6'b000101)        // B
      w_ctrl = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 3'd2, 3'd0, 2'd0, 1'b0, 1'b0};
    else if (w_op[10:3] == 8'b01010100)      // B.LT
      w_ctrl = '{w_lt, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 3'd0, 3'd0, 2'd0, 1'b0, 1'b0};
    else if (w_op[10:3] == 8'b10110100)      // CBZ
      w_ctrl = '{zero_comparator, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 3'd0, 3'd0, 2'd3, 1'b0, 1'b0};
    else if (w_op == 11'b11111000010)        // LDUR
      w_ctrl = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 3'd2, 3'd1, 2'd0, 1'b0, 1'b0};
    else if (w_op == 11'b00111000010)        // LDURB
      w_ctrl = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd2, 3'd2, 3'd3, 2'd0, 1'b0, 1'b0};
    else if (w_op[10:2] == 9'b111100101)     // MOVK
      w_ctrl = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 3'd2, 3'd0, 2'd2, 1'b0, 1'b1};
    else if (w_op[10:2] == 9'b110100101)     // MOVZ
      w_ctrl = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 3'd2, 3'd0, 2'd1, 1'b0, 1'b0};
    else if (w_op == 11'b11111000000)        // STUR
      w_ctrl = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 3'd2, 3'd0, 2'd0, 1'b0, 1'b0};
    else if (w_op == 11'b00111000000)        // STURB
      w_ctrl = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd2, 3'd2, 3'd0, 2'd0, 1'b0, 1'b0};
    else if (w_op == 11'b11101011000)        // SUBS
      w_ctrl = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 3'd3, 3'd0, 2'd0, 1'b1, 1'b0};
  end

  // Architectural NZCV register: loads live ALU flags on flag-setting ops
  always_ff @(posedge clk) begin
    if (reset)               r_flags <= 4'b0000;
    else if (w_ctrl.flag_en) r_flags <= {negativef, zerof, carryf, overflowf};
  end

  assign BrTaken         = w_ctrl.br;
  assign Reg2Loc         = w_ctrl.reg2loc;
  assign RegWrite        = w_ctrl.regwrite;
  assign MemRead         = w_ctrl.memread;
  assign MemWrite        = w_ctrl.memwrite;
  assign UnCondBr        = w_ctrl.uncondbr;
  assign xsize_loc       = w_ctrl.xsize;
  assign ALUSrc          = w_ctrl.alusrc;
  assign ALUOp           = w_ctrl.aluop;
  assign MemtoReg        = w_ctrl.memtoreg;
  assign ALU_first_i_sel = w_ctrl.first_sel;
  assign flag_enable     = w_ctrl.flag_en;
  assign RdLoc           = w_ctrl.rdloc;

endmodule

// File: tb/tb_control_path.sv
// tb_control_path: directed test-plan steps followed by random instructions,
// flags and resets, checked against a table-driven reference model.
module tb_control_path;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instruct_bits;
  logic        negativef, overflowf, carryf, zerof, zero_comparator;
  logic        flag_enable, BrTaken, Reg2Loc, RdLoc, RegWrite, MemRead, MemWrite;
  logic        UnCondBr, xsize_loc;
  logic [2:0]  ALUSrc, ALUOp, MemtoReg;
  logic [1:0]  ALU_first_i_sel;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state: stored flags and whether last cycle wrote flags
  logic m_n = 1'b0, m_z = 1'b0, m_c = 1'b0, m_v = 1'b0, m_pend = 1'b0;
  logic [19:0] m_exp;

  // Opcode prefixes in priority order: value and prefix length
  int          p_len [12] = '{10, 11, 6, 8, 8, 11, 11, 9, 9, 11, 11, 11};
  logic [31:0] p_val [12];
  logic [19:0] p_vec [12];
  logic [19:0] v_nop;

  control_path dut (
    .clk(clk), .reset(reset), .instruct_bits(instruct_bits),
    .negativef(negativef), .overflowf(overflowf), .carryf(carryf), .zerof(zerof),
    .zero_comparator(zero_comparator), .flag_enable(flag_enable), .BrTaken(BrTaken),
    .Reg2Loc(Reg2Loc), .RdLoc(RdLoc), .RegWrite(RegWrite), .MemRead(MemRead),
    .MemWrite(MemWrite), .UnCondBr(UnCondBr), .xsize_loc(xsize_loc), .ALUSrc(ALUSrc),
    .ALUOp(ALUOp), .MemtoReg(MemtoReg), .ALU_first_i_sel(ALU_first_i_sel)
  );

  always #5 clk = ~clk;

  function automatic logic [19:0] mk(int br, int r2, int rw, int mr, int mw, int ub,
                                     int xs, int src, int op, int m2r, int fi, int fe, int rd);
    logic [19:0] v;
    v[19] = br[0];  v[18] = r2[0]; v[17] = rw[0]; v[16] = mr[0]; v[15] = mw[0];
    v[14] = ub[0];  v[13] = xs[0]; v[12:10] = src[2:0]; v[9:7] = op[2:0];
    v[6:4] = m2r[2:0]; v[3:2] = fi[1:0]; v[1] = fe[0]; v[0] = rd[0];
    return v;
  endfunction

  function automatic logic [19:0] dut_vec();
    return {BrTaken, Reg2Loc, RegWrite, MemRead, MemWrite, UnCondBr, xsize_loc,
            ALUSrc, ALUOp, MemtoReg, ALU_first_i_sel, flag_enable, RdLoc};
  endfunction

  // Expected control vector from the instruction tables
  function automatic logic [19:0] model(logic [31:0] ins, logic rst, logic zc, logic lt);
    logic [19:0] v;
    if (rst) return v_nop;
    for (int i = 0; i < 12; i++) begin
      if ((ins >> (32 - p_len[i])) == p_val[i]) begin
        v = p_vec[i];
        if (i == 3) v[19] = lt;
        if (i == 4) v[19] = zc;
        return v;
      end
    end
    return v_nop;
  endfunction

  task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs and compare the full control vector
  task automatic apply(input string tag, input logic [31:0] ins, input logic rst,
                       input logic [3:0] nvcz, input logic zc);
    logic lt;
    instruct_bits = ins; reset = rst; zero_comparator = zc;
    {negativef, overflowf, carryf, zerof} = nvcz;
    #2;
    lt = m_n ^ m_v;
`ifdef FLAG_BYPASS_EN
    if (m_pend) lt = negativef ^ overflowf;
`endif
    m_exp = model(ins, rst, zc, lt);
    chk(tag, dut_vec(), m_exp);
  endtask

  // Clock edge and reference-state update
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      {m_n, m_z, m_c, m_v} = 4'b0000;
      m_pend = 1'b0;
    end else begin
      if (m_exp[1]) {m_n, m_z, m_c, m_v} = {negativef, zerof, carryf, overflowf};
      m_pend = m_exp[1];
    end
    #1;
  endtask

  initial begin
    logic [31:0] ins, mask;
    int k;
    p_val = '{32'b1001000100, 32'b10101011000, 32'b000101, 32'b01010100, 32'b10110100,
              32'b11111000010, 32'b00111000010, 32'b111100101, 32'b110100101,
              32'b11111000000, 32'b00111000000, 32'b11101011000};
    p_vec[0]  = mk(0,1,1,0,0,1,1,0,2,0,0,0,0);
    p_vec[1]  = mk(0,0,1,0,0,0,1,1,2,0,0,1,0);
    p_vec[2]  = mk(1,0,0,0,0,1,1,0,2,0,0,0,0);
    p_vec[3]  = mk(0,0,0,0,0,0,1,0,0,0,0,0,0);
    p_vec[4]  = mk(0,1,0,0,0,0,1,1,0,0,3,0,0);
    p_vec[5]  = mk(0,1,1,1,0,0,0,2,2,1,0,0,0);
    p_vec[6]  = mk(0,1,1,1,0,0,1,2,2,3,0,0,0);
    p_vec[7]  = mk(0,1,1,0,0,0,0,3,2,0,2,0,1);
    p_vec[8]  = mk(0,0,1,0,0,0,0,3,2,0,1,0,0);
    p_vec[9]  = mk(0,1,0,0,1,0,0,2,2,0,0,0,0);
    p_vec[10] = mk(0,1,0,0,1,0,1,2,2,0,0,0,0);
    p_vec[11] = mk(0,0,1,0,0,0,1,1,3,0,0,1,0);
    v_nop     = mk(0,0,0,0,0,0,1,0,0,0,0,0,0);

    // Reset overrides decode (SUBS under reset must give NOP, no flag load)
    apply("reset_subs", 32'hEB0003E1, 1'b1, 4'b1111, 1'b1);
    chk1("reset_fe", flag_enable, 1'b0);
    tick();
    apply("addi", 32'h910003E0, 1'b0, 4'b0000, 1'b0);
    chk1("addi_uncond", UnCondBr, 1'b1);
    tick();

    // SUBS with N=0 V=1 then B.LT must be taken
    apply("subs", 32'hEB0003E1, 1'b0, 4'b0111, 1'b0);  // {N,V,C,Z}
    chk1("subs_fe", flag_enable, 1'b1);
    tick();
    apply("blt_taken", 32'h5400010B, 1'b0, 4'b0000, 1'b0);
    chk1("blt_br", BrTaken, 1'b1);
    tick();
    apply("blt_hold", 32'h5400010B, 1'b0, 4'b1000, 1'b0);
    chk1("blt_hold_br", BrTaken, 1'b1);
    tick();
    apply("reset_mid", 32'h5400010B, 1'b1, 4'b0000, 1'b0);
    tick();
    apply("blt_after_rst", 32'h5400010B, 1'b0, 4'b0100, 1'b0);
    chk1("blt_after_rst_br", BrTaken, 1'b0);
    tick();

    apply("cbz_z1", 32'hB400029F, 1'b0, 4'b0000, 1'b1);
    chk1("cbz_z1_br", BrTaken, 1'b1);
    apply("cbz_z0", 32'hB400029F, 1'b0, 4'b0000, 1'b0);
    chk1("cbz_z0_br", BrTaken, 1'b0);
    tick();
    apply("ldur",  32'hF8405087, 1'b0, 4'b0000, 1'b0); tick();
    apply("ldurb", 32'h384083E8, 1'b0, 4'b0000, 1'b0); tick();
    apply("stur",  32'hF8008062, 1'b0, 4'b0000, 1'b0); tick();
    apply("sturb", 32'h380023E0, 1'b0, 4'b0000, 1'b0); tick();
    apply("movk",  32'hF2DBD5A1, 1'b0, 4'b0000, 1'b0);
    chk1("movk_rdloc", RdLoc, 1'b1);
    tick();
    apply("movz",  32'hD2B7DDE0, 1'b0, 4'b0000, 1'b0); tick();
    apply("b",     32'h14000000, 1'b0, 4'b0000, 1'b0); tick();
    apply("adds",  32'hAB010006, 1'b0, 4'b1000, 1'b0); tick();
    apply("nop",   32'h00000000, 1'b0, 4'b0000, 1'b0); tick();

    // Random mix of decodable and arbitrary words, flags and resets
    for (int n = 0; n < 400; n++) begin
      k = $urandom_range(0, 14);
      ins = $urandom;
      if (k < 12) begin
        mask = 32'hFFFFFFFF >> p_len[k];
        ins = (p_val[k] << (32 - p_len[k])) | (ins & mask);
      end
      apply("rand", ins, ($urandom_range(0, 15) == 0), 4'($urandom), 1'($urandom));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
